mem_arbiter: RTL and testbench

- Shares one single-port, tri-state-bus `memory` instance (AWIDTH-bit addr, DWIDTH-bit inout data, wr/rd strobes) between two requesters.
- Round-robin grant; valid/ready request handshake per requester; one-cycle response pulse per requester.
- Sequences the memory's strobe timing and owns the controller side of the bidirectional data bus.
- Sits between two client blocks and the memory.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    // Width of a requester id: two requesters need one bit.
    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester that did not win last.
// Latency: combinational.
// Backpressure: no grant while enable_i is low.
// Ports: req_i request vector, last_grant_i previous winner, enable_i grant window,
//        gnt_o one-hot grant, gnt_id_o id of the granted requester.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0]      req_i,
    input  logic [ID_W-1:0] last_grant_i,
    input  logic            enable_i,
    output logic [1:0]      gnt_o,
    output logic [ID_W-1:0] gnt_id_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_id_o = '0;
        if (enable_i) begin
            case (req_i)
                2'b01: begin
                    gnt_o    = 2'b01;
                    gnt_id_o = ID_W'(0);
                end
                2'b10: begin
                    gnt_o    = 2'b10;
                    gnt_id_o = ID_W'(1);
                end
                2'b11: begin
                    gnt_id_o = ~last_grant_i;
                    gnt_o    = (gnt_id_o != '0) ? 2'b10 : 2'b01;
                end
                default: begin
                    gnt_o    = 2'b00;
                    gnt_id_o = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port tri-state memory between two requesters with round-robin grant.
// Latency: write response 2 cycles after accept, read response 3 cycles after accept.
// Backpressure: reqN_ready only in IDLE for the granted requester; one transaction in flight.
// Ports: reqN_* valid/ready request channels, rspN_* one-cycle response pulse + read data,
//        mem_wr/mem_rd/mem_addr strobes to the memory, mem_data bidirectional data bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    state_e                   state_q, state_d;
    logic [AWIDTH-1:0]        addr_q;
    logic [DWIDTH-1:0]        wdata_q;
    logic [ID_W-1:0]          owner_q;
    logic [ID_W-1:0]          last_grant_q;
    logic [1:0]               rsp_vld_q;
    logic [1:0][DWIDTH-1:0]   rsp_rdata_q;

    logic [1:0]               gnt;
    logic [ID_W-1:0]          gnt_id;
    logic                     accept;
    logic                     sel_we;
    logic [AWIDTH-1:0]        sel_addr;
    logic [DWIDTH-1:0]        sel_wdata;

    rr_arbiter2 u_arb (
        .req_i        ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == ST_IDLE),
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

    // A grant is only ever given to a valid requester, so any grant is an accept.
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    assign sel_we    = (gnt_id != '0) ? req1_we    : req0_we;
    assign sel_addr  = (gnt_id != '0) ? req1_addr  : req0_addr;
    assign sel_wdata = (gnt_id != '0) ? req1_wdata : req0_wdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = sel_we ? ST_WR : ST_RD1;
            ST_WR:   state_d = ST_IDLE;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= ID_W'(1);   // requester 0 wins the first tie
            rsp_vld_q    <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_vld_q <= '0;
            if (accept) begin
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                owner_q      <= gnt_id;
                last_grant_q <= gnt_id;
            end
            if (state_q == ST_WR) begin
                rsp_vld_q[owner_q]   <= 1'b1;
                rsp_rdata_q[owner_q] <= '0;
            end
            // Memory drives its registered output during RD2; sample on the closing edge.
            if (state_q == ST_RD2) begin
                rsp_vld_q[owner_q]   <= 1'b1;
                rsp_rdata_q[owner_q] <= mem_data;
            end
        end
    end

    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp0_rdata = rsp_rdata_q[0];
    assign rsp1_rdata = rsp_rdata_q[1];

    // Strobes come only from registered state so the memory never sees request-input glitches.
    assign mem_wr   = (state_q == ST_WR);
    assign mem_rd   = (state_q == ST_RD1) || (state_q == ST_RD2);
    assign mem_addr = addr_q;
    // Bus is driven only in WR; IDLE between WR and RD1 gives a dead cycle for turnaround.
    assign mem_data = (state_q == ST_WR) ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_wr, mem_rd;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;
    exp_t sb[2][$];

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Memory: writes on the edge closing a mem_wr cycle; registers read data on a mem_rd
    // edge and drives the bus while mem_rd stays high afterwards.
    logic [DW-1:0] mem_arr [32];
    logic [DW-1:0] mem_out_q;
    logic          mem_oe_q;
    initial begin
        mem_out_q = '0;
        mem_oe_q  = 1'b0;
        for (int i = 0; i < 32; i++) mem_arr[i] = DW'(i * 17);
        forever begin
            @(posedge clk);
            if (mem_wr) mem_arr[mem_addr] <= mem_data;
            if (mem_rd) mem_out_q <= mem_arr[mem_addr];
            mem_oe_q <= mem_rd;
        end
    end
    assign mem_data = (mem_oe_q && mem_rd) ? mem_out_q : {DW{1'bz}};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle when inputs are stable.
    initial begin
        logic [DW-1:0] ref_mem [32];
        logic [DW-1:0] last_rd [2];
        logic          lg;
        int            busy, wr_run, rd_run, n;
        logic [AW-1:0] cur_addr;
        logic          idle, e0, e1, rv, we;
        logic [DW-1:0] rd, wd;
        logic [AW-1:0] a;
        exp_t          it;
        for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i * 17);
        lg = 1'b1; busy = 0; wr_run = 0; rd_run = 0; cur_addr = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb[0].delete(); sb[1].delete();
                lg = 1'b1; busy = 0; wr_run = 0; rd_run = 0;
                last_rd[0] = '0; last_rd[1] = '0;
                continue;
            end
            for (int k = 0; k < 2; k++) begin
                rv = (k == 0) ? rsp0_valid : rsp1_valid;
                rd = (k == 0) ? rsp0_rdata : rsp1_rdata;
                if (rv) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("rsp%0d_unexpected_valid", k), rv, 0);
                    end else begin
                        it = sb[k].pop_front();
                        chk($sformatf("rsp%0d_rdata", k), rd, it.rdata);
                        chk($sformatf("rsp%0d_latency", k), cyc, it.due);
                    end
                    last_rd[k] = rd;
                end else begin
                    chk($sformatf("rsp%0d_rdata_hold", k), rd, last_rd[k]);
                    if (sb[k].size() > 0 && sb[k][0].due < cyc) begin
                        chk($sformatf("rsp%0d_missing", k), rv, 1);
                        void'(sb[k].pop_front());
                    end
                end
            end
            // Round-robin grant: only when no transaction is in flight.
            idle = (cyc >= busy);
            e0 = idle && req0_valid && (!req1_valid || lg == 1'b1);
            e1 = idle && req1_valid && (!req0_valid || lg == 1'b0);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            if (e0 || e1) begin
                n  = e1 ? 1 : 0;
                we = e1 ? req1_we : req0_we;
                a  = e1 ? req1_addr : req0_addr;
                wd = e1 ? req1_wdata : req0_wdata;
                lg = e1;
                busy = cyc + (we ? 2 : 3);
                it.due   = busy;
                it.rdata = we ? '0 : ref_mem[a];
                if (we) ref_mem[a] = wd;
                cur_addr = a;
                sb[n].push_back(it);
            end
            // Memory-side protocol.
            chk("strobe_exclusive", mem_wr && mem_rd, 0);
            if (mem_wr || mem_rd) chk("mem_addr", mem_addr, cur_addr);
            if (mem_wr) chk("wr_bus_unknown", $isunknown(mem_data), 0);
            if (mem_rd && mem_oe_q) chk("rd2_bus_unknown", $isunknown(mem_data), 0);
            if (mem_wr) wr_run++;
            else if (wr_run != 0) begin chk("mem_wr_width", wr_run, 1); wr_run = 0; end
            if (mem_rd) rd_run++;
            else if (rd_run != 0) begin chk("mem_rd_width", rd_run, 2); rd_run = 0; end
        end
    end

    task automatic req_op(input int n, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int patience, input bit must);
        bit acc = 0;
        if (n == 0) begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
        else        begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
        for (int k = 0; k < patience; k++) begin
            @(negedge clk);
            if (((n == 0) ? req0_ready : req1_ready) == 1'b1) begin acc = 1; break; end
        end
        @(posedge clk); #1;
        if (n == 0) req0_valid = 0; else req1_valid = 0;
        if (must) chk($sformatf("accept_req%0d", n), acc, 1);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic rand_proc(input int n, input int ops);
        for (int i = 0; i < ops; i++) begin
            int g;
            g = $urandom_range(0, 2);
            if (g > 0) begin repeat (g) @(posedge clk); #1; end
            req_op(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
                   $urandom_range(1, 6), 1'b0);
        end
    endtask

    initial begin
        #2 rst_n = 0;
        #10;
        chk("reset_mem_wr", mem_wr, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_data_z", mem_data === {DW{1'bz}}, 1);
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_req1_ready", req1_ready, 0);
        chk("reset_rsp0_valid", rsp0_valid, 0);
        chk("reset_rsp1_valid", rsp1_valid, 0);
        chk("reset_rsp0_rdata", rsp0_rdata, 0);
        chk("reset_rsp1_rdata", rsp1_rdata, 0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // Write then read back from requester 0.
        req_op(0, 1, 5'h03, 8'hA5, 50, 1);
        req_op(0, 0, 5'h03, 8'h00, 50, 1);
        drain();

        // Simultaneous reads from reset: requester 0 first, then again on the next tie.
        do_reset();
        fork
            req_op(0, 0, 5'h01, 8'h00, 50, 1);
            req_op(1, 0, 5'h02, 8'h00, 50, 1);
        join
        fork
            req_op(0, 0, 5'h02, 8'h00, 50, 1);
            req_op(1, 0, 5'h01, 8'h00, 50, 1);
        join
        drain();

        // Both hold valid for six transactions.
        fork
            repeat (3) req_op(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), 50, 1);
            repeat (3) req_op(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), 50, 1);
        join
        drain();

        // Write from requester 1, read of the same word by requester 0 right behind it.
        fork
            req_op(1, 1, 5'h1F, 8'h5A, 50, 1);
            begin @(posedge clk); #1; req_op(0, 0, 5'h1F, 8'h00, 50, 1); end
        join
        drain();

        // Reset during RD2: strobes and bus drop at once, no response.
        req_op(0, 0, 5'h03, 8'h00, 50, 1);
        @(posedge clk); #2;
        chk("rd2_mem_rd_before_reset", mem_rd, 1);
        rst_n = 0;
        #1;
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_mem_data_z", mem_data === {DW{1'bz}}, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        req_op(0, 0, 5'h03, 8'h00, 50, 1);
        drain();

        // Lone requester 1 write.
        req_op(1, 1, 5'h07, 8'hC3, 50, 1);
        drain();

        // Randomized traffic, including requests withdrawn before being accepted.
        fork
            rand_proc(0, 30);
            rand_proc(1, 30);
        join
        drain();
        drain();
        chk("sb0_empty", sb[0].size(), 0);
        chk("sb1_empty", sb[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
